dtw_match_select: RTL and testbench
===================================

Name: dtw_match_select

Overview:
- Sits directly downstream of the DTW scorer and sequences one comparison per stored word template.
- For each template it drives the template select and pulses the scorer start. It then waits for the scorer done and captures its score.
- After the last template it reports the minimum-score word, or a rejection, to the command/display logic.

Parameters:
NUM_WORDS, 4, number of stored templates compared per utterance (1..16)
IDX_W, 2, width of the word index; must satisfy 2^IDX_W >= NUM_WORDS
SCORE_W, 26, width of scorer score
TIMEOUT, 4095, max cycles waited for a scorer done before abort; wait counter is 12 bits
MARGIN, 256, best-vs-runner-up minimum separation (used only with the optional feature)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
go  in  1  one-cycle pulse: start classifying the current utterance
threshold  in  SCORE_W  acceptance limit; best score must be <= threshold
score_start  out  1  one-cycle pulse to scorer start
word_sel  out  IDX_W  template index currently being scored (drives template memory select)
score_in  in  SCORE_W  scorer result, valid at scorer done
score_done  in  1  scorer done; level, held high until the scorer's next start
busy  out  1  high from the cycle after an accepted go until match_valid
match_valid  out  1  one-cycle pulse: result fields updated
match_idx  out  IDX_W  index of lowest-score template
match_score  out  SCORE_W  lowest score observed
no_match  out  1  result rejected (over threshold, timeout, or ambiguous)
timeout_err  out  1  sticky: scorer failed to finish; cleared by the next accepted go

Behaviour:
- Reset (clock, reset synchronous active-high): state IDLE. All outputs 0: score_start, word_sel, busy, match_valid, match_idx, match_score, no_match, timeout_err. Internal best_score = all-ones; best_idx, wait counter and done_q are cleared.
- Done detection:
  - done_q registers score_done every cycle.
  - done_rise = score_done & ~done_q.
  - Only a rising edge counts as a completion. A level left high from a previous run is ignored.
- IDLE: on go, load best_score = all-ones, best_idx = 0, word_sel = 0, and clear timeout_err and no_match; go to ISSUE. go in any other state is ignored.
- ISSUE: assert score_start for exactly this cycle, clear the wait counter, go to WAIT_SCORE. go->score_start latency is 1 cycle.
- WAIT_SCORE:
  - On done_rise, latch score_in into cur_score and go to COMPARE.
  - Otherwise increment the wait counter. When it reaches TIMEOUT, set timeout_err = 1 and no_match = 1, then go to DONE.
  - A done_rise in the same cycle the counter reaches TIMEOUT is accepted as a completion (no timeout).
- COMPARE:
  - If cur_score < best_score (strict), update best_score and best_idx. On a tie the lower index wins.
  - If word_sel == NUM_WORDS-1, go to DONE. Otherwise increment word_sel and go to ISSUE.
  - word_sel is stable from ISSUE through COMPARE for each template.
- DONE:
  - Drive match_idx = best_idx and match_score = best_score.
  - Set no_match |= (best_score > threshold).
  - Pulse match_valid for one cycle, then go to IDLE.
  - Result fields hold until the next accepted go; busy drops in this cycle.
- On timeout, match_idx/match_score reflect the best of the templates completed so far. If none completed, they are 0 and all-ones.
- Cycles per template: 3 + scorer latency (ISSUE, detect, COMPARE).
- threshold is sampled in DONE only.
- Reset mid-operation returns to IDLE immediately. No score_start is issued in the reset cycle.

Optional Feature:
- Macro: DTW_MATCH_MARGIN_EN
- Defined: also track runner_up_score (all-ones at go). In COMPARE:
  - New best: runner_up takes the old best.
  - Else if cur_score < runner_up: runner_up takes cur_score.
  - In DONE, additionally set no_match when NUM_WORDS > 1 and (runner_up_score - best_score) < MARGIN. The difference is computed SCORE_W+1 wide.
- Undefined: no runner-up logic; MARGIN unused; rejection is by threshold and timeout only.

Test Plan:
- NUM_WORDS=4, threshold=5000, scorer model returns 9000, 3000, 7000, 3000 -> match_idx=1, match_score=3000, no_match=0. Exactly 4 score_start pulses with word_sel 0,1,2,3; one match_valid pulse.
- Same but scores 6000, 8000, 5001, 9000 -> match_idx=2, match_score=5001, no_match=1.
- Model never raises done on word 2 -> after 4095 wait cycles: timeout_err=1, no_match=1, match_valid pulse, match_idx=0, match_score=6000 (scores 6000, 7000 before).
- score_done held high from a previous run when go arrives -> no completion until the model drops and re-raises done. Extra go pulses while busy produce no extra score_start.
- Assert reset during WAIT_SCORE of word 1 -> next cycle: all outputs 0, IDLE. A following go restarts at word_sel=0.
- With DTW_MATCH_MARGIN_EN, MARGIN=256, scores 3000, 3100, 8000, 9000, threshold 5000 -> match_idx=0, no_match=1. Scores 3000, 3400, ... -> no_match=0.

Source files
------------

// File: rtl/dtw_match_select.sv
// Steps the DTW scorer through every stored word template and reports the lowest-score word or a rejection.
// Optional build macro DTW_MATCH_MARGIN_EN adds best-vs-runner-up separation checking.
`timescale 1ns/1ps
module dtw_match_select #(
    parameter int NUM_WORDS = 4,
    parameter int IDX_W     = 2,
    parameter int SCORE_W   = 26,
    parameter int TIMEOUT   = 4095,
    parameter int MARGIN    = 256
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               go,
    input  logic [SCORE_W-1:0] threshold,
    output logic               score_start,
    output logic [IDX_W-1:0]   word_sel,
    input  logic [SCORE_W-1:0] score_in,
    input  logic               score_done,
    output logic               busy,
    output logic               match_valid,
    output logic [IDX_W-1:0]   match_idx,
    output logic [SCORE_W-1:0] match_score,
    output logic               no_match,
    output logic               timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_COMPARE,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_WORDS - 1);
    localparam logic [11:0]        TIMEOUT_CNT = 12'(TIMEOUT);
    localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     word_sel_q, word_sel_d;
    logic [SCORE_W-1:0]   best_score_q, best_score_d;
    logic [IDX_W-1:0]     best_idx_q, best_idx_d;
    logic [SCORE_W-1:0]   cur_score_q, cur_score_d;
    logic [11:0]          wait_cnt_q, wait_cnt_d;
    logic                 done_q;
    logic                 match_valid_q, match_valid_d;
    logic [IDX_W-1:0]     match_idx_q, match_idx_d;
    logic [SCORE_W-1:0]   match_score_q, match_score_d;
    logic                 no_match_q, no_match_d;
    logic                 timeout_err_q, timeout_err_d;
    logic                 done_rise;
    logic                 ambiguous;

    // A done level left over from the previous comparison must not count as a completion.
    assign done_rise = score_done & ~done_q;

`ifdef DTW_MATCH_MARGIN_EN
    logic [SCORE_W-1:0] runner_up_q, runner_up_d;
    logic [SCORE_W:0]   separation;

    assign separation = {1'b0, runner_up_q} - {1'b0, best_score_q};
    assign ambiguous  = (NUM_WORDS > 1) && (separation < (SCORE_W+1)'(MARGIN));

    always_ff @(posedge clock) begin
        if (reset) begin
            runner_up_q <= SCORE_MAX;
        end else begin
            runner_up_q <= runner_up_d;
        end
    end
`else
    // Without runner-up tracking the separation check folds away to a constant 0.
    assign ambiguous = (MARGIN < 0);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            word_sel_q    <= '0;
            best_score_q  <= SCORE_MAX;
            best_idx_q    <= '0;
            wait_cnt_q    <= '0;
            done_q        <= 1'b0;
            match_valid_q <= 1'b0;
            match_idx_q   <= '0;
            match_score_q <= '0;
            no_match_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_sel_q    <= word_sel_d;
            best_score_q  <= best_score_d;
            best_idx_q    <= best_idx_d;
            wait_cnt_q    <= wait_cnt_d;
            done_q        <= score_done;
            match_valid_q <= match_valid_d;
            match_idx_q   <= match_idx_d;
            match_score_q <= match_score_d;
            no_match_q    <= no_match_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Captured score is pure data and is always overwritten before use.
    always_ff @(posedge clock) begin
        cur_score_q <= cur_score_d;
    end

    always_comb begin
        state_d       = state_q;
        word_sel_d    = word_sel_q;
        best_score_d  = best_score_q;
        best_idx_d    = best_idx_q;
        cur_score_d   = cur_score_q;
        wait_cnt_d    = wait_cnt_q;
        match_valid_d = 1'b0;
        match_idx_d   = match_idx_q;
        match_score_d = match_score_q;
        no_match_d    = no_match_q;
        timeout_err_d = timeout_err_q;
`ifdef DTW_MATCH_MARGIN_EN
        runner_up_d   = runner_up_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    best_score_d  = SCORE_MAX;
                    best_idx_d    = '0;
                    word_sel_d    = '0;
                    timeout_err_d = 1'b0;
                    no_match_d    = 1'b0;
`ifdef DTW_MATCH_MARGIN_EN
                    runner_up_d   = SCORE_MAX;
`endif
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (done_rise) begin
                    cur_score_d = score_in;
                    state_d     = S_COMPARE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 12'd1;
                    if (wait_cnt_d == TIMEOUT_CNT) begin
                        timeout_err_d = 1'b1;
                        no_match_d    = 1'b1;
                        state_d       = S_DONE;
                    end
                end
            end
            S_COMPARE: begin
                // Strict compare keeps the lower index on a tie.
                if (cur_score_q < best_score_q) begin
                    best_score_d = cur_score_q;
                    best_idx_d   = word_sel_q;
`ifdef DTW_MATCH_MARGIN_EN
                    runner_up_d  = best_score_q;
                end else if (cur_score_q < runner_up_q) begin
                    runner_up_d  = cur_score_q;
`endif
                end
                if (word_sel_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    word_sel_d = word_sel_q + IDX_W'(1);
                    state_d    = S_ISSUE;
                end
            end
            S_DONE: begin
                match_idx_d   = best_idx_q;
                match_score_d = best_score_q;
                no_match_d    = no_match_q | (best_score_q > threshold) | ambiguous;
                match_valid_d = 1'b1;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Gated by reset so a mid-run reset never leaks a start pulse to the scorer.
    assign score_start = (state_q == S_ISSUE) & ~reset;
    assign busy        = (state_q == S_ISSUE) | (state_q == S_WAIT) | (state_q == S_COMPARE);
    assign word_sel    = word_sel_q;
    assign match_valid = match_valid_q;
    assign match_idx   = match_idx_q;
    assign match_score = match_score_q;
    assign no_match    = no_match_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_dtw_match_select.sv
// Bench for dtw_match_select: behavioural scorer, table of directed cases, random runs against a min-search model.
`timescale 1ns/1ps
module tb_dtw_match_select;

    localparam int NW = 4;
    localparam int IW = 2;
    localparam int SW = 26;
    localparam int TO = 4095;
    localparam int MG = 256;
`ifdef DTW_MATCH_MARGIN_EN
    localparam bit MEN = 1'b1;
`else
    localparam bit MEN = 1'b0;
`endif
    localparam logic [SW-1:0] ONES = '1;

    logic          clock = 1'b0;
    logic          reset;
    logic          go;
    logic [SW-1:0] threshold;
    logic          score_start;
    logic [IW-1:0] word_sel;
    logic [SW-1:0] score_in;
    logic          score_done;
    logic          busy;
    logic          match_valid;
    logic [IW-1:0] match_idx;
    logic [SW-1:0] match_score;
    logic          no_match;
    logic          timeout_err;

    always #5 clock = ~clock;

    dtw_match_select #(
        .NUM_WORDS(NW), .IDX_W(IW), .SCORE_W(SW), .TIMEOUT(TO), .MARGIN(MG)
    ) dut (
        .clock(clock), .reset(reset), .go(go), .threshold(threshold),
        .score_start(score_start), .word_sel(word_sel), .score_in(score_in),
        .score_done(score_done), .busy(busy), .match_valid(match_valid),
        .match_idx(match_idx), .match_score(match_score), .no_match(no_match),
        .timeout_err(timeout_err)
    );

    typedef struct {
        logic [NW-1:0][SW-1:0] sc;
        logic [NW-1:0][15:0]   lat;
        int                    hang;
        int                    stale;
        logic [SW-1:0]         thr;
        int                    x_idx;
        logic [SW-1:0]         x_score;
        bit                    x_nm;
        bit                    x_to;
    } vec_t;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scorer: drops done on start (or after a stale hold), raises it lat cycles later.
    logic [SW-1:0] m_sc [NW];
    int            m_lat [NW];
    int            m_hang;
    int            m_stale;
    int            hold_cnt;
    int            lat_cnt;
    int            cur_w;
    logic          active;

    always @(posedge clock) begin
        if (reset) begin
            score_done <= 1'b0;
            active     <= 1'b0;
            hold_cnt   <= 0;
            lat_cnt    <= 0;
        end else if (score_start) begin
            cur_w   <= int'(word_sel);
            active  <= (int'(word_sel) != m_hang);
            lat_cnt <= m_lat[word_sel];
            if (m_stale > 0 && word_sel == '0) begin
                hold_cnt <= m_stale;
                score_in <= '0;
            end else begin
                hold_cnt   <= 0;
                score_done <= 1'b0;
            end
        end else if (active) begin
            if (hold_cnt > 0) begin
                hold_cnt <= hold_cnt - 1;
                if (hold_cnt == 1) score_done <= 1'b0;
            end else if (lat_cnt > 1) begin
                lat_cnt <= lat_cnt - 1;
            end else begin
                score_done <= 1'b1;
                score_in   <= m_sc[cur_w];
                active     <= 1'b0;
            end
        end
    end

    logic [IW-1:0] starts_q [$];
    int            mv_cnt = 0;

    always @(negedge clock) begin
        if (score_start) starts_q.push_back(word_sel);
        if (match_valid) mv_cnt <= mv_cnt + 1;
    end

    function automatic vec_t mk(input int s0, s1, s2, s3, l0, l1, l2, l3, hang, stale,
                                input logic [SW-1:0] thr, input int xi,
                                input logic [SW-1:0] xs, input bit xnm, input bit xto);
        vec_t v;
        v.sc[0] = SW'(s0); v.sc[1] = SW'(s1); v.sc[2] = SW'(s2); v.sc[3] = SW'(s3);
        v.lat[0] = 16'(l0); v.lat[1] = 16'(l1); v.lat[2] = 16'(l2); v.lat[3] = 16'(l3);
        v.hang = hang; v.stale = stale; v.thr = thr;
        v.x_idx = xi; v.x_score = xs; v.x_nm = xnm; v.x_to = xto;
        return v;
    endfunction

    // Reference: a word completes if its scorer answers inside the wait window; take the
    // minimum of the completed scores (first occurrence wins) and the second smallest as runner-up.
    function automatic vec_t predict(input vec_t v);
        vec_t          r = v;
        logic [SW-1:0] done_sc [$];
        logic [SW-1:0] sorted [$];
        logic [SW-1:0] best, runner;
        bit            to = 1'b0;
        for (int w = 0; w < NW; w++) begin
            int delay = int'(v.lat[w]) + ((w == 0) ? v.stale : 0);
            if (w == v.hang || delay >= TO) begin
                to = 1'b1;
                break;
            end
            done_sc.push_back(v.sc[w]);
        end
        sorted = done_sc;
        sorted.sort();
        best   = (sorted.size() > 0) ? sorted[0] : ONES;
        runner = (sorted.size() > 1) ? sorted[1] : ONES;
        r.x_idx = 0;
        for (int k = done_sc.size() - 1; k >= 0; k--)
            if (done_sc[k] == best) r.x_idx = k;
        r.x_score = best;
        r.x_to    = to;
        r.x_nm    = to || (best > v.thr) ||
                    (MEN && NW > 1 && ({1'b0, runner} - {1'b0, best}) < (SW+1)'(MG));
        return r;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, " score_start"}, score_start, 0);
        chk({tag, " word_sel"}, word_sel, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " match_valid"}, match_valid, 0);
        chk({tag, " match_idx"}, match_idx, 0);
        chk({tag, " match_score"}, match_score, 0);
        chk({tag, " no_match"}, no_match, 0);
        chk({tag, " timeout_err"}, timeout_err, 0);
    endtask

    task automatic run_case(input vec_t v, input string tag, input bit extra_go);
        int base, mv0, n, n_starts, exp_starts;
        for (int w = 0; w < NW; w++) begin
            m_sc[w]  = v.sc[w];
            m_lat[w] = int'(v.lat[w]);
        end
        m_hang    = v.hang;
        m_stale   = v.stale;
        threshold = v.thr;
        base      = starts_q.size();
        mv0       = mv_cnt;
        @(negedge clock); go = 1'b1;
        @(negedge clock); go = 1'b0;
        chk({tag, " start latency"}, score_start, 1);
        chk({tag, " busy"}, busy, 1);
        if (extra_go) begin
            repeat (3) begin
                @(negedge clock); go = 1'b1;
                @(negedge clock); go = 1'b0;
            end
        end
        n = 0;
        while (!match_valid && n < 9000) begin
            @(negedge clock);
            n++;
        end
        if (!match_valid) begin
            chk({tag, " match_valid wait"}, 0, 1);
            return;
        end
        chk({tag, " match_idx"}, match_idx, v.x_idx);
        chk({tag, " match_score"}, match_score, v.x_score);
        chk({tag, " no_match"}, no_match, v.x_nm);
        chk({tag, " timeout_err"}, timeout_err, v.x_to);
        chk({tag, " busy at result"}, busy, 0);
        n_starts   = starts_q.size() - base;
        exp_starts = NW;
        if (v.x_to) begin
            exp_starts = 0;
            for (int w = 0; w < NW; w++) begin
                int delay = int'(v.lat[w]) + ((w == 0) ? v.stale : 0);
                if (w == v.hang || delay >= TO) begin
                    exp_starts = w + 1;
                    break;
                end
            end
        end
        chk({tag, " start count"}, n_starts, exp_starts);
        for (int k = 0; k < n_starts && k < NW; k++)
            chk($sformatf("%s word_sel at start %0d", tag, k), starts_q[base + k], k);
        @(negedge clock);
        chk({tag, " match_valid one cycle"}, match_valid, 0);
        chk({tag, " match_idx hold"}, match_idx, v.x_idx);
        @(negedge clock);
        chk({tag, " match_valid pulses"}, mv_cnt - mv0, 1);
    endtask

    vec_t tbl [11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   base, n;
        reset = 1'b1;
        go = 1'b0;
        threshold = '0;
        m_hang = -1;
        m_stale = 0;
        for (int w = 0; w < NW; w++) begin
            m_sc[w]  = '0;
            m_lat[w] = 1;
        end
        repeat (3) @(negedge clock);
        check_zero("reset");
        reset = 1'b0;
        @(negedge clock);
        check_zero("post-reset");

        tbl[0]  = mk(9000, 3000, 7000, 3000, 2, 3, 1, 4, -1, 0, 5000, 1, 3000, 0, 0);
        tbl[1]  = mk(6000, 8000, 5001, 9000, 3, 3, 3, 3, -1, 5, 5000, 2, 5001, 1, 0);
        tbl[2]  = mk(6000, 7000, 1, 2, 2, 2, 2, 2, 2, 0, 5000, 0, 6000, 1, 1);
        tbl[3]  = mk(5000, 6000, 7000, 8000, 1, 1, 1, 1, -1, 0, 5000, 0, 5000, 0, 0);
        tbl[4]  = mk(-1, -1, -1, -1, 1, 2, 1, 2, -1, 0, ONES, 0, ONES, MEN, 0);
        tbl[5]  = mk(100, 200, 300, 50, 4094, 1, 1, 1, -1, 0, 5000, 3, 50, 0, 0);
        tbl[6]  = mk(100, 200, 300, 50, 4095, 1, 1, 1, -1, 0, 5000, 0, ONES, 1, 1);
        tbl[7]  = mk(3000, 3100, 8000, 9000, 2, 2, 2, 2, -1, 0, 5000, 0, 3000, MEN, 0);
        tbl[8]  = mk(3000, 3400, 8000, 9000, 2, 2, 2, 2, -1, 0, 5000, 0, 3000, 0, 0);
        tbl[9]  = mk(700, 400, 400, 400, 1, 2, 3, 1, -1, 0, 400, 1, 400, MEN, 0);
        tbl[10] = mk(10, 20, 30, 40, 1, 1, 1, 1, 0, 0, 5000, 0, ONES, 1, 1);

        for (int i = 0; i < 11; i++)
            run_case(tbl[i], $sformatf("vec%0d", i), (i == 0));

        // Reset while waiting on word 1, then a clean restart from word 0.
        v = mk(1000, 2000, 3000, 4000, 20, 20, 20, 20, -1, 0, 5000, 0, 1000, 0, 0);
        for (int w = 0; w < NW; w++) begin
            m_sc[w]  = v.sc[w];
            m_lat[w] = int'(v.lat[w]);
        end
        m_hang = -1;
        m_stale = 0;
        threshold = v.thr;
        base = starts_q.size();
        @(negedge clock); go = 1'b1;
        @(negedge clock); go = 1'b0;
        n = 0;
        while (starts_q.size() < base + 2 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("midreset reached word 1", starts_q.size() - base, 2);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_zero("midreset");
        reset = 1'b0;
        run_case(v, "after midreset", 1'b0);

        for (int r = 0; r < 30; r++) begin
            v.hang  = -1;
            v.stale = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            v.thr   = SW'($urandom_range(0, 8000));
            for (int w = 0; w < NW; w++) begin
                v.sc[w]  = ($urandom_range(0, 4) == 0) ? SW'($urandom) : SW'($urandom_range(0, 15) * 500);
                v.lat[w] = 16'($urandom_range(1, 6));
            end
            v = predict(v);
            run_case(v, $sformatf("rand%0d", r), ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
